// File: rtl/conv_scan_ctrl_pkg.sv
// Shared definitions for the convolution scan controller: FSM state
// encoding and the bit offset of one element inside the packed result map.
package conv_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_FINISH  = 3'd4
  } scan_state_e;

  // Bit offset of element (r,c); the map is row-major, element 0 at the MSB end.
  function automatic int unsigned res_offset(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned len,
                                             input int unsigned dw);
    return (r * len + c) * dw;
  endfunction

endpackage

// File: rtl/conv_anchor_counter.sv
// Row/column window counters with wrap, a last-window flag, and the
// stride-scaled anchors of the position the counters move to next.
module conv_anchor_counter #(
  parameter int data_width    = 16,
  parameter int result_length = 2,
  parameter int result_width  = 2,
  parameter int stride        = 1,
  localparam int RW = $clog2(result_width) + 1,
  localparam int CW = $clog2(result_length) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  step_i,
  output logic [RW-1:0]         row_o,
  output logic [CW-1:0]         col_o,
  output logic                  last_o,
  output logic [data_width-1:0] anchor_2d_nxt_o,
  output logic [data_width-1:0] anchor_1d_nxt_o
);

  localparam logic [RW-1:0]         ROW_LAST = RW'(result_width - 1);
  localparam logic [CW-1:0]         COL_LAST = CW'(result_length - 1);
  localparam logic [data_width-1:0] STRIDE_W = data_width'(stride);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          row_end, col_end;

  assign row_end = (row_q == ROW_LAST);
  assign col_end = (col_q == COL_LAST);

  // Next counter position: clear on scan start, otherwise step column-first.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (step_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o           = row_q;
  assign col_o           = col_q;
  assign last_o          = row_end && col_end;
  assign anchor_2d_nxt_o = data_width'(row_d) * STRIDE_W;
  assign anchor_1d_nxt_o = data_width'(col_d) * STRIDE_W;

endmodule

// File: rtl/conv_scan_ctrl.sv
// Scan controller: walks the window anchors over the output grid, waits for
// one MAC result per window and packs the results into a flat map.
module conv_scan_ctrl
  import conv_scan_ctrl_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int result_length = 2,
  parameter int result_width  = 2,
  parameter int stride        = 1,
  parameter int mac_timeout   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mac_valid,
  input  logic [data_width-1:0] mac_result,
  output logic                  conv_en,
  output logic [data_width-1:0] archor_2D,
  output logic [data_width-1:0] archor_1D,
  output logic [0:result_width*result_length*data_width-1] result,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int N_BITS = result_width * result_length * data_width;
  localparam int OW     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int RW     = $clog2(result_width) + 1;
  localparam int CW     = $clog2(result_length) + 1;
  localparam int TW     = (mac_timeout > 1) ? $clog2(mac_timeout) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((mac_timeout > 0) ? mac_timeout - 1 : 0);
  localparam bit TMO_EN = (mac_timeout != 0);

  scan_state_e           state_q;
  logic                  conv_en_q, busy_q, done_q, error_q;
  logic [data_width-1:0] anchor_2d_q, anchor_1d_q;
  logic [0:N_BITS-1]     result_q;
  logic [TW-1:0]         tmo_q;

  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  last_win;
  logic [data_width-1:0] anchor_2d_nxt, anchor_1d_nxt;
  logic                  cnt_clr, cnt_step;
  logic [OW-1:0]         wr_off;

  assign cnt_clr  = (state_q == ST_IDLE) && start;
  assign cnt_step = (state_q == ST_ADVANCE);
  assign wr_off   = OW'(res_offset(32'(row), 32'(col), result_length, data_width));

  conv_anchor_counter #(
    .data_width   (data_width),
    .result_length(result_length),
    .result_width (result_width),
    .stride       (stride)
  ) u_cnt (
    .clk            (clk),
    .rst_n          (reset),
    .clr_i          (cnt_clr),
    .step_i         (cnt_step),
    .row_o          (row),
    .col_o          (col),
    .last_o         (last_win),
    .anchor_2d_nxt_o(anchor_2d_nxt),
    .anchor_1d_nxt_o(anchor_1d_nxt)
  );

  // Scan FSM with registered outputs, MAC timeout counter and result map.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      conv_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      anchor_2d_q <= '0;
      anchor_1d_q <= '0;
      result_q    <= '0;
      tmo_q       <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_LOAD;
            result_q    <= '0;
            busy_q      <= 1'b1;
            conv_en_q   <= 1'b1;
            anchor_2d_q <= '0;
            anchor_1d_q <= '0;
            tmo_q       <= '0;
          end
        end
        // Buffer latches the window during this cycle; MAC output is not yet meaningful.
        ST_LOAD: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (mac_valid) begin
            result_q[wr_off +: data_width] <= mac_result;
            conv_en_q <= 1'b0;
            state_q   <= ST_ADVANCE;
          end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
            error_q   <= 1'b1;
            busy_q    <= 1'b0;
            conv_en_q <= 1'b0;
            tmo_q     <= '0;
            state_q   <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_ADVANCE: begin
          tmo_q <= '0;
          if (last_win) begin
            state_q <= ST_FINISH;
          end else begin
            state_q     <= ST_LOAD;
            conv_en_q   <= 1'b1;
            anchor_2d_q <= anchor_2d_nxt;
            anchor_1d_q <= anchor_1d_nxt;
          end
        end
        ST_FINISH: begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          anchor_2d_q <= '0;
          anchor_1d_q <= '0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign conv_en   = conv_en_q;
  assign archor_2D = anchor_2d_q;
  assign archor_1D = anchor_1d_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Scoreboard bench: stimulus pushes expected windows/completions into queues,
// monitors pop and compare whenever the DUTs present a window, done or error.
module tb_conv_scan_ctrl;

  localparam int DW = 16;
  localparam int NB = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic          start_a = 1'b0, mac_valid_a = 1'b0;
  logic [DW-1:0] mac_result_a = '0;
  logic          conv_en_a, busy_a, done_a, error_a;
  logic [DW-1:0] a2_a, a1_a;
  logic [0:NB-1] res_a;

  logic          start_b = 1'b0, mac_valid_b = 1'b0;
  logic [DW-1:0] mac_result_b = '0;
  logic          conv_en_b, busy_b, done_b, error_b;
  logic [DW-1:0] a2_b, a1_b;
  logic [0:NB-1] res_b;

  typedef struct { logic [DW-1:0] a2; logic [DW-1:0] a1; } win_t;
  typedef struct { logic [NB-1:0] res; int dly; } end_t;

  win_t exp_win_a[$], exp_win_b[$];
  end_t exp_done_a[$], exp_err_a[$], exp_done_b[$];

  int cyc = 0;
  int checks = 0, failures = 0;
  int start_cyc_a = 0, start_cyc_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_scan_ctrl #(.data_width(16), .result_length(2), .result_width(2),
                   .stride(1), .mac_timeout(8)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mac_valid(mac_valid_a),
    .mac_result(mac_result_a), .conv_en(conv_en_a), .archor_2D(a2_a),
    .archor_1D(a1_a), .result(res_a), .busy(busy_a), .done(done_a), .error(error_a));

  conv_scan_ctrl #(.data_width(16), .result_length(2), .result_width(2),
                   .stride(2), .mac_timeout(64)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mac_valid(mac_valid_b),
    .mac_result(mac_result_b), .conv_en(conv_en_b), .archor_2D(a2_b),
    .archor_1D(a1_b), .result(res_b), .busy(busy_b), .done(done_b), .error(error_b));

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic push_win(input bit b, input logic [DW-1:0] r, input logic [DW-1:0] c);
    win_t w;
    w.a2 = r; w.a1 = c;
    if (b) exp_win_b.push_back(w); else exp_win_a.push_back(w);
  endtask

  task automatic push_end(input int kind, input logic [NB-1:0] res, input int dly);
    end_t e;
    e.res = res; e.dly = dly;
    if (kind == 0) exp_done_a.push_back(e);
    else if (kind == 1) exp_err_a.push_back(e);
    else exp_done_b.push_back(e);
  endtask

  task automatic start_scan(input bit b);
    @(negedge clk);
    if (b) begin start_b = 1'b1; start_cyc_b = cyc; end
    else   begin start_a = 1'b1; start_cyc_a = cyc; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Waits for the next window load, then answers after lat WAIT cycles.
  task automatic drive_win(input bit b, input int lat, input logic [DW-1:0] val, input bit junk);
    int n = 0;
    while (((b ? conv_en_b : conv_en_a) == 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(b ? "win_wait_b" : "win_wait_a", b ? conv_en_b : conv_en_a, 1);
    if ((b ? conv_en_b : conv_en_a) == 1'b0) return;
    if (junk && !b) begin
      start_a = 1'b1; mac_valid_a = 1'b1; mac_result_a = 16'hDEAD;
    end
    repeat (lat) begin
      @(negedge clk);
      start_a = 1'b0; mac_valid_a = 1'b0;
    end
    if (b) begin mac_valid_b = 1'b1; mac_result_b = val; end
    else   begin mac_valid_a = 1'b1; mac_result_a = val; end
    @(negedge clk);
    mac_valid_a = 1'b0;
    mac_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input bit b);
    int n = 0;
    while ((b ? busy_b : busy_a) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk(b ? "idle_wait_b" : "idle_wait_a", b ? busy_b : busy_a, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic scan4_a(input int lat, input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                         input logic [DW-1:0] v2, input logic [DW-1:0] v3, input bit junk);
    push_win(0, 0, 0); push_win(0, 0, 1); push_win(0, 1, 0); push_win(0, 1, 1);
    push_end(0, {v0, v1, v2, v3}, 4 * (2 + lat) + 1);
    start_scan(0);
    drive_win(0, lat, v0, 1'b0);
    drive_win(0, lat, v1, junk);
    drive_win(0, lat, v2, junk);
    drive_win(0, lat, v3, 1'b0);
    wait_idle(0);
  endtask

  // Monitor for instance A: window anchors, anchor stability, done and error.
  initial begin : mon_a
    logic          prev_en;
    logic [DW-1:0] h2, h1;
    int            rise_cyc;
    win_t          w;
    end_t          e;
    prev_en = 1'b0; h2 = '0; h1 = '0; rise_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev_en = 1'b0;
      end else begin
        if (conv_en_a && !prev_en) begin
          rise_cyc = cyc; h2 = a2_a; h1 = a1_a;
          if (exp_win_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL win_a_unexpected: got (%0d,%0d) required no window", a2_a, a1_a);
          end else begin
            w = exp_win_a.pop_front();
            $display("A window anchors (%0d,%0d) at cycle %0d", a2_a, a1_a, cyc);
            chk("win_a_2D", a2_a, w.a2);
            chk("win_a_1D", a1_a, w.a1);
          end
        end else if (conv_en_a) begin
          chk("hold_a_2D", a2_a, h2);
          chk("hold_a_1D", a1_a, h1);
        end
        if (done_a) begin
          if (exp_done_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_a_unexpected: got done=1 required 0");
          end else begin
            e = exp_done_a.pop_front();
            $display("A done result=%h after %0d cycles", res_a, cyc - start_cyc_a - 1);
            chk("done_a_result", res_a, e.res);
            chk("done_a_cycles", cyc - start_cyc_a - 1, e.dly);
            chk("done_a_busy", busy_a, 0);
          end
        end
        if (error_a) begin
          if (exp_err_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL error_a_unexpected: got error=1 required 0");
          end else begin
            e = exp_err_a.pop_front();
            $display("A error result=%h %0d cycles after load", res_a, cyc - rise_cyc);
            chk("err_a_result", res_a, e.res);
            chk("err_a_cycles", cyc - rise_cyc, e.dly);
            chk("err_a_busy", busy_a, 0);
            chk("err_a_conv_en", conv_en_a, 0);
          end
        end
        prev_en = conv_en_a;
      end
    end
  end

  // Monitor for instance B: window anchors, single-cycle gap between windows, done.
  initial begin : mon_b
    logic prev_en;
    bit   in_scan;
    int   low_cnt;
    win_t w;
    end_t e;
    prev_en = 1'b0; in_scan = 1'b0; low_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev_en = 1'b0; in_scan = 1'b0; low_cnt = 0;
      end else begin
        if (conv_en_b && !prev_en) begin
          if (in_scan) chk("gap_b", low_cnt, 1);
          in_scan = 1'b1;
          low_cnt = 0;
          if (exp_win_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL win_b_unexpected: got (%0d,%0d) required no window", a2_b, a1_b);
          end else begin
            w = exp_win_b.pop_front();
            $display("B window anchors (%0d,%0d) at cycle %0d", a2_b, a1_b, cyc);
            chk("win_b_2D", a2_b, w.a2);
            chk("win_b_1D", a1_b, w.a1);
          end
        end else if (!conv_en_b) begin
          low_cnt++;
        end
        if (done_b) begin
          in_scan = 1'b0;
          if (exp_done_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_b_unexpected: got done=1 required 0");
          end else begin
            e = exp_done_b.pop_front();
            $display("B done result=%h after %0d cycles", res_b, cyc - start_cyc_b - 1);
            chk("done_b_result", res_b, e.res);
            chk("done_b_cycles", cyc - start_cyc_b - 1, e.dly);
          end
        end
        chk("err_b_quiet", error_b, 0);
        prev_en = conv_en_b;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_conv_en", conv_en_a, 0);
    chk("rst_anchors", {a2_a, a1_a}, 0);
    chk("rst_result", res_a, 0);
    chk("rst_flags", {busy_a, done_a, error_a}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("scenario 1: default scan");
    scan4_a(1, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 1'b0);

    $display("scenario 2: stride 2");
    push_win(1, 0, 0); push_win(1, 0, 2); push_win(1, 2, 0); push_win(1, 2, 2);
    push_end(2, 64'h0102_0304_0506_0708, 13);
    start_scan(1);
    drive_win(1, 1, 16'h0102, 1'b0);
    drive_win(1, 1, 16'h0304, 1'b0);
    drive_win(1, 1, 16'h0506, 1'b0);
    drive_win(1, 1, 16'h0708, 1'b0);
    wait_idle(1);

    $display("scenario 3: MAC latency 5");
    scan4_a(5, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);

    $display("scenario 4: MAC timeout on second window");
    push_win(0, 0, 0); push_win(0, 0, 1);
    push_end(1, 64'hABCD_0000_0000_0000, 9);
    start_scan(0);
    drive_win(0, 1, 16'hABCD, 1'b0);
    wait_idle(0);

    $display("scenario 5: reset during third window");
    push_win(0, 0, 0); push_win(0, 0, 1); push_win(0, 1, 0);
    start_scan(0);
    drive_win(0, 1, 16'h5555, 1'b0);
    drive_win(0, 1, 16'h6666, 1'b0);
    n = 0;
    while (!conv_en_a && n < 40) begin @(negedge clk); n++; end
    chk("win3_load_a", conv_en_a, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_conv_en", conv_en_a, 0);
    chk("arst_2D", a2_a, 0);
    chk("arst_1D", a1_a, 0);
    chk("arst_result", res_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_pulses", {done_a, error_a}, 0);
    chk("arst_result_b", res_b, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    scan4_a(1, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 1'b0);

    $display("scenario 6: stray start and mac_valid ignored");
    @(negedge clk);
    mac_valid_a = 1'b1; mac_result_a = 16'hBEEF;
    @(negedge clk);
    mac_valid_a = 1'b0;
    chk("idle_valid_busy", busy_a, 0);
    scan4_a(1, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 1'b1);

    repeat (4) @(negedge clk);
    chk("left_win_a", exp_win_a.size(), 0);
    chk("left_done_a", exp_done_a.size(), 0);
    chk("left_err_a", exp_err_a.size(), 0);
    chk("left_win_b", exp_win_b.size(), 0);
    chk("left_done_b", exp_done_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
